// File: rtl/cpu_debug_ocimem_pkg.sv
// Shared types and jdo field positions for the OCI RAM arbiter.
// JDO_W is the full jdo width.
package cpu_debug_ocimem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        JRD,
        ARD
    } ocimem_state_e;

    typedef enum logic {
        GNT_JTAG,
        GNT_AV
    } ocimem_grant_e;

    localparam int unsigned JDO_W         = 38;
    localparam int unsigned JDO_ADDR_LSB  = 2;
    localparam int unsigned JDO_RDEN_BIT  = 35;
    localparam int unsigned JDO_WDATA_LSB = 3;

endpackage

// File: rtl/cpu_debug_ocimem_jtag_cmd.sv
// JTAG ocimem command capture.
// Holds one pending command, the auto-incrementing address and the sticky overrun flag.
module cpu_debug_ocimem_jtag_cmd
    import cpu_debug_ocimem_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [JDO_W-1:0]  jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              in_flight,
    input  logic              retire,
    output logic              pending,
    output logic              pending_wr,
    output logic [DATA_W-1:0] pending_wdata,
    output logic [ADDR_W-1:0] jtag_addr,
    output logic              overrun
);

    logic              pending_q, pending_d;
    logic              wr_q, wr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              overrun_q, overrun_d;

    logic busy;
    logic any_strobe;
    logic accept;

    assign busy       = pending_q | in_flight;
    assign any_strobe = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
    // A strobe arriving in the retiring cycle is taken, since the slot frees at this edge.
    assign accept     = any_strobe & (~busy | retire);

    always_comb begin
        pending_d = pending_q;
        wr_d      = wr_q;
        wdata_d   = wdata_q;
        addr_d    = addr_q;
        overrun_d = overrun_q | (any_strobe & ~accept);

        if (retire) begin
            pending_d = 1'b0;
            addr_d    = addr_q + 1'b1;
        end

        if (accept) begin
            if (take_action_ocimem_a) begin
                // A new address load overrides the post-retire increment.
                addr_d = jdo[JDO_ADDR_LSB +: ADDR_W];
                if (jdo[JDO_RDEN_BIT]) begin
                    pending_d = 1'b1;
                    wr_d      = 1'b0;
                end
            end else if (take_no_action_ocimem_a) begin
                pending_d = 1'b1;
                wr_d      = 1'b0;
            end else begin
                pending_d = 1'b1;
                wr_d      = 1'b1;
                wdata_d   = jdo[JDO_WDATA_LSB +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_q <= 1'b0;
            wr_q      <= 1'b0;
            wdata_q   <= '0;
            addr_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
            wr_q      <= wr_d;
            wdata_q   <= wdata_d;
            addr_q    <= addr_d;
            overrun_q <= overrun_d;
        end
    end

    assign pending       = pending_q;
    assign pending_wr    = wr_q;
    assign pending_wdata = wdata_q;
    assign jtag_addr     = addr_q;
    assign overrun       = overrun_q;

endmodule

// File: rtl/cpu_debug_ocimem_arbiter.sv
// Round-robin arbiter sharing the single-port OCI RAM between the JTAG debug path
// and the Avalon debug_mem_slave port.
module cpu_debug_ocimem_arbiter
    import cpu_debug_ocimem_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [JDO_W-1:0]    jdo,
    input  logic                take_action_ocimem_a,
    input  logic                take_no_action_ocimem_a,
    input  logic                take_action_ocimem_b,
    input  logic [ADDR_W-1:0]   av_address,
    input  logic                av_read,
    input  logic                av_write,
    input  logic [DATA_W-1:0]   av_writedata,
    input  logic [DATA_W/8-1:0] av_byteenable,
    output logic                av_waitrequest,
    output logic [DATA_W-1:0]   av_readdata,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic                ram_wren,
    output logic [DATA_W/8-1:0] ram_byteen,
    output logic [DATA_W-1:0]   ram_wdata,
    input  logic [DATA_W-1:0]   ram_rdata,
    output logic [DATA_W-1:0]   MonDReg,
    output logic                jtag_busy,
    output logic                jtag_overrun
);

    ocimem_state_e state_q, state_d;
    ocimem_grant_e last_grant_q, last_grant_d;
    logic [DATA_W-1:0] mon_q;

    logic              jtag_pending;
    logic              jtag_pending_wr;
    logic [DATA_W-1:0] jtag_wdata;
    logic [ADDR_W-1:0] jtag_addr;
    logic              jtag_retire;
    logic              av_req;
    logic              grant_jtag;

    cpu_debug_ocimem_jtag_cmd #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_jtag_cmd (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .in_flight               (state_q == JRD),
        .retire                  (jtag_retire),
        .pending                 (jtag_pending),
        .pending_wr              (jtag_pending_wr),
        .pending_wdata           (jtag_wdata),
        .jtag_addr               (jtag_addr),
        .overrun                 (jtag_overrun)
    );

    assign av_req     = av_read | av_write;
    assign grant_jtag = jtag_pending & (~av_req | (last_grant_q == GNT_AV));

    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        av_waitrequest = 1'b1;
        ram_wren       = 1'b0;
        ram_addr       = '0;
        ram_byteen     = '0;
        ram_wdata      = '0;
        jtag_retire    = 1'b0;

        case (state_q)
            IDLE: begin
                // Gating with reset_n keeps a held Avalon write from reaching the RAM in reset.
                if (reset_n && (jtag_pending || av_req)) begin
                    if (grant_jtag) begin
                        last_grant_d = GNT_JTAG;
                        ram_addr     = jtag_addr;
                        if (jtag_pending_wr) begin
                            ram_wren    = 1'b1;
                            ram_byteen  = '1;
                            ram_wdata   = jtag_wdata;
                            jtag_retire = 1'b1;
                        end else begin
                            state_d = JRD;
                        end
                    end else begin
                        last_grant_d = GNT_AV;
                        ram_addr     = av_address;
                        if (av_write) begin
                            ram_wren       = 1'b1;
                            ram_byteen     = av_byteenable;
                            ram_wdata      = av_writedata;
                            av_waitrequest = 1'b0;
                        end else begin
                            state_d = ARD;
                        end
                    end
                end
            end
            JRD: begin
                jtag_retire = 1'b1;
                state_d     = IDLE;
            end
            ARD: begin
                av_waitrequest = 1'b0;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            last_grant_q <= GNT_AV;
            mon_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            if (state_q == JRD) begin
                mon_q <= ram_rdata;
            end
        end
    end

    assign av_readdata = (state_q == ARD) ? ram_rdata : '0;
    assign MonDReg     = mon_q;
    assign jtag_busy   = jtag_pending | (state_q == JRD);

endmodule

// File: doc/cpu_debug_ocimem_arbiter.md
Name: cpu_debug_ocimem_arbiter

Overview:
- Shares the Nios II on-chip debug instruction memory (OCI RAM, single-port, 1-cycle read latency) between two requesters:
  - the JTAG debug path, which sends sysclk-domain take_action strobes plus jdo;
  - the CPU's Avalon debug_mem_slave port.
- Captures JTAG ocimem commands, auto-increments the JTAG address and arbitrates round-robin.
- Returns JTAG read data on MonDReg for the debug slave's shift register.

Parameters:
- ADDR_W, 8, OCI RAM word-address width (256 x 32-bit words).
- DATA_W, 32, data width. Fixed at 32 by the jdo field layout.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- jdo  in  38  JTAG data out, sysclk-synchronised.
- take_action_ocimem_a  in  1  pulse: load JTAG address; optional read.
- take_no_action_ocimem_a  in  1  pulse: read at current JTAG address.
- take_action_ocimem_b  in  1  pulse: write at current JTAG address.
- av_address  in  ADDR_W  Avalon word address.
- av_read  in  1  Avalon read request.
- av_write  in  1  Avalon write request.
- av_writedata  in  32  Avalon write data.
- av_byteenable  in  4  Avalon byte enables.
- av_waitrequest  out  1  Avalon stall.
- av_readdata  out  32  Avalon read data.
- ram_addr  out  ADDR_W  RAM address.
- ram_wren  out  1  RAM write enable.
- ram_byteen  out  4  RAM byte enables.
- ram_wdata  out  32  RAM write data.
- ram_rdata  in  32  RAM read data, valid the cycle after the address.
- MonDReg  out  32  last JTAG read data.
- jtag_busy  out  1  JTAG command pending or in flight.
- jtag_overrun  out  1  sticky: JTAG strobe dropped while busy.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; jtag_addr=0; pending=0; MonDReg=0; jtag_overrun=0; last_grant=AV.
  - av_waitrequest=1; ram_wren=0; ram_addr=0; av_readdata=0.
- JTAG command capture:
  - take_action_ocimem_a: jtag_addr<=jdo[ADDR_W+1:2]. If jdo[35]=1, queue a read (pending=RD).
  - take_no_action_ocimem_a: queue a read at jtag_addr.
  - take_action_ocimem_b: queue a write of jdo[34:3], byteen=4'hF, at jtag_addr.
  - Strobe while pending/in flight: command ignored, jtag_overrun<=1. It clears only on reset.
  - Strobe in the same cycle the previous command retires: accepted.
  - More than one strobe in a cycle cannot occur. Priority if it does: a > no_action_a > b.
- FSM states: IDLE, JRD, ARD.
- Arbitration in IDLE, when both the JTAG pending command and the Avalon request (av_read|av_write) are valid:
  - grant the requester not in last_grant (round-robin);
  - update last_grant on every grant;
  - a single requester is granted immediately.
- Avalon write granted in cycle N:
  - ram_addr/wdata/byteen driven from Avalon, ram_wren=1, av_waitrequest=0, all in cycle N;
  - stay IDLE.
- Avalon read granted in cycle N:
  - ram_addr=av_address, av_waitrequest=1, next state ARD.
  - ARD (N+1): av_readdata<=ram_rdata (combinational pass-through), av_waitrequest=0, return to IDLE.
- JTAG write granted:
  - ram_wren=1 that cycle;
  - jtag_addr<=jtag_addr+1, wrapping 2^ADDR_W-1 -> 0;
  - pending cleared; stay IDLE.
- JTAG read granted in N:
  - ram_addr=jtag_addr, next state JRD.
  - JRD (N+1): MonDReg<=ram_rdata, jtag_addr increments with wrap, pending cleared, return to IDLE.
- av_waitrequest is 1 in every cycle not listed above, including IDLE with no Avalon request. The Avalon master must hold its request stable while waitrequest=1.
- av_read and av_write both high: treated as a write.
- jtag_busy = pending | (state==JRD).
- ram_wren is never 1 outside an IDLE grant cycle.
- Reset mid-operation (JRD/ARD): the operation is aborted and MonDReg is not updated.

Decomposition:
- Package cpu_debug_ocimem_pkg:
  - state enum {IDLE, JRD, ARD};
  - grant enum {GNT_JTAG, GNT_AV};
  - constants JDO_ADDR_LSB=2, JDO_RDEN_BIT=35, JDO_WDATA_LSB=3.
- Sub-module cpu_debug_ocimem_jtag_cmd: command register, pending flag, address counter with wrap, overrun flag.
- Top level holds the arbiter FSM and the RAM/Avalon muxing.

Test Plan:
- JTAG write path: ocimem_a with jdo[9:2]=8'h10, jdo[35]=0, then ocimem_b with data 32'hDEADBEEF -> RAM[0x10]=DEADBEEF, jtag_addr=0x11.
- JTAG read path: ocimem_a with addr 0x10 and jdo[35]=1 -> MonDReg=DEADBEEF two cycles after the strobe, jtag_addr=0x11, jtag_busy low afterwards.
- Avalon timing: write 0x20<-0x12345678 with byteen=4'b0011 -> waitrequest low in the same cycle, only bytes 0-1 change. Read 0x20 -> waitrequest high 1 cycle, then readdata with low half 0x5678.
- Contention:
  - JTAG read pending and av_read held continuously, last_grant=AV -> JTAG served first, Avalon next.
  - Then JTAG and Avalon re-request together -> Avalon served (alternation).
- Wrap and overrun:
  - address 0xFF, two ocimem_b writes -> second lands at 0x00;
  - ocimem_b issued while JRD in progress -> dropped, jtag_overrun=1.
- Reset asserted in ARD -> av_waitrequest=1, no RAM write, all registers at reset values after release.
